// File: rtl/asteroid_pkg.sv
// Shared types and constants for the asteroid hit judge.
// ASTEROID_HIT_BCD_EN selects the packed-BCD score helper used by the top.
package asteroid_pkg;

    localparam int unsigned X_W        = 8;
    localparam int unsigned Y_W        = 7;
    localparam int unsigned SCORE_W    = 8;
    localparam int unsigned LIVES_W    = 2;
    localparam int unsigned DEF_RADIUS = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PLAY = 2'b01,
        S_HIT  = 2'b10,
        S_OVER = 2'b11
    } state_e;

    // Two-digit packed BCD increment, saturating at 99.
    function automatic logic [SCORE_W-1:0] bcd_inc(input logic [SCORE_W-1:0] s);
        logic [SCORE_W-1:0] r;
        r = s;
        if (s == 8'h99) begin
            r = s;
        end else if (s[3:0] == 4'd9) begin
            r = {4'(s[7:4] + 4'd1), 4'd0};
        end else begin
            r = {s[7:4], 4'(s[3:0] + 4'd1)};
        end
        return r;
    endfunction

endpackage

// File: rtl/hit_box_cmp.sv
// Two-stage bullet/asteroid box overlap pipeline with per-stage valid and flush.
module hit_box_cmp
    import asteroid_pkg::*;
#(
    parameter int unsigned RADIUS = DEF_RADIUS
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic [X_W-1:0] ast_x_i,
    input  logic [Y_W-1:0] ast_y_i,
    input  logic [X_W-1:0] bullet_x_i,
    input  logic [Y_W-1:0] bullet_y_i,
    input  logic           ast_active_i,
    input  logic           bullet_valid_i,
    input  logic           flush_i,
    output logic           hit_o
);

    logic [X_W-1:0] dx_d, dx_q;
    logic [Y_W-1:0] dy_d, dy_q;
    logic           valid1_d, valid1_q;
    logic           hit_d, hit_q;

    // Non-wrapping absolute differences: larger minus smaller.
    always_comb begin
        dx_d     = (ast_x_i >= bullet_x_i) ? (ast_x_i - bullet_x_i) : (bullet_x_i - ast_x_i);
        dy_d     = (ast_y_i >= bullet_y_i) ? (ast_y_i - bullet_y_i) : (bullet_y_i - ast_y_i);
        valid1_d = ast_active_i & bullet_valid_i & ~flush_i;
        hit_d    = valid1_q & ~flush_i
                 & (dx_q <= X_W'(RADIUS))
                 & (dy_q <= Y_W'(RADIUS));
    end

    // Stage 1 distance registers and stage 2 hit register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dx_q     <= '0;
            dy_q     <= '0;
            valid1_q <= 1'b0;
            hit_q    <= 1'b0;
        end else begin
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            valid1_q <= valid1_d;
            hit_q    <= hit_d;
        end
    end

    assign hit_o = hit_q;

endmodule

// File: rtl/asteroid_hit_judge.sv
// Asteroid hit judge: overlap detection, destroy handshake, score and lives.
// ASTEROID_HIT_BCD_EN: score kept as two packed BCD digits saturating at 8'h99.
module asteroid_hit_judge
    import asteroid_pkg::*;
#(
    parameter int unsigned RADIUS    = DEF_RADIUS,
    parameter int unsigned LIVES     = 3,
    parameter int unsigned SCORE_INC = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [X_W-1:0]     ast_x,
    input  logic [Y_W-1:0]     ast_y,
    input  logic               ast_active,
    input  logic               ast_done,
    input  logic               destroyed,
    input  logic [X_W-1:0]     bullet_x,
    input  logic [Y_W-1:0]     bullet_y,
    input  logic               bullet_valid,
    output logic               destroy,
    output logic               bullet_clear,
    output logic [SCORE_W-1:0] score,
    output logic [LIVES_W-1:0] lives,
    output logic               game_over
);

    state_e               state_q;
    logic                 destroy_q;
    logic                 bullet_clear_q;
    logic [SCORE_W-1:0]   score_q;
    logic [LIVES_W-1:0]   lives_q;
    logic                 game_over_q;
    logic                 hit;
    logic                 flush_c;
    logic [SCORE_W-1:0]   score_inc_c;

    // Pipeline is flushed on the hit-accept cycle and held empty during the handshake.
    assign flush_c = (state_q == S_HIT) | ((state_q == S_PLAY) & hit);

    hit_box_cmp #(
        .RADIUS (RADIUS)
    ) u_hit_box_cmp (
        .clk_i          (clock),
        .rst_ni         (reset),
        .ast_x_i        (ast_x),
        .ast_y_i        (ast_y),
        .bullet_x_i     (bullet_x),
        .bullet_y_i     (bullet_y),
        .ast_active_i   (ast_active),
        .bullet_valid_i (bullet_valid),
        .flush_i        (flush_c),
        .hit_o          (hit)
    );

`ifdef ASTEROID_HIT_BCD_EN
    // Packed-BCD saturating score increment.
    always_comb begin
        score_inc_c = bcd_inc(score_q);
    end
`else
    logic [SCORE_W:0] score_sum_c;

    // Binary saturating score increment.
    always_comb begin
        score_sum_c = {1'b0, score_q} + (SCORE_W+1)'(SCORE_INC);
        score_inc_c = score_sum_c[SCORE_W] ? {SCORE_W{1'b1}} : score_sum_c[SCORE_W-1:0];
    end
`endif

    // Game FSM with registered handshake, score and lives.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            destroy_q      <= 1'b0;
            bullet_clear_q <= 1'b0;
            score_q        <= '0;
            lives_q        <= '0;
            game_over_q    <= 1'b0;
        end else begin
            bullet_clear_q <= 1'b0;
            case (state_q)
                S_IDLE, S_OVER: begin
                    if (start) begin
                        state_q     <= S_PLAY;
                        lives_q     <= LIVES_W'(LIVES);
                        score_q     <= '0;
                        game_over_q <= 1'b0;
                        destroy_q   <= 1'b0;
                    end
                end
                S_PLAY: begin
                    if (hit) begin
                        state_q        <= S_HIT;
                        destroy_q      <= 1'b1;
                        bullet_clear_q <= 1'b1;
                    end else if (ast_done) begin
                        if (lives_q != '0) begin
                            lives_q <= lives_q - LIVES_W'(1);
                        end
                        if (lives_q == LIVES_W'(1)) begin
                            state_q     <= S_OVER;
                            game_over_q <= 1'b1;
                        end
                    end
                end
                S_HIT: begin
                    if (destroyed) begin
                        destroy_q <= 1'b0;
                        score_q   <= score_inc_c;
                        state_q   <= S_PLAY;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign destroy      = destroy_q;
    assign bullet_clear = bullet_clear_q;
    assign score        = score_q;
    assign lives        = lives_q;
    assign game_over    = game_over_q;

endmodule

// File: doc/asteroid_hit_judge.md
Name: asteroid_hit_judge

Overview:
Sits directly downstream of the asteroid mover. Consumes the asteroid's live position (current_x/current_y) and its move-done pulse, together with the player's bullet position. Detects bullet/asteroid overlap and drives the asteroid's destroy input through a destroy/destroyed handshake. Keeps score and lives, and flags game over to the top-level game FSM.

Parameters:
RADIUS, 5, asteroid half-extent in pixels for the box overlap test (matches the asteroid's radius)
LIVES, 3, lives loaded on start; range 1..3
SCORE_INC, 1, points added per confirmed hit

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset (asserted at 0)
start  in  1  one-cycle pulse: begin a new game
ast_x  in  8  asteroid centre x (asteroid current_x)
ast_y  in  7  asteroid centre y (asteroid current_y)
ast_active  in  1  asteroid in flight (high from its go until move done)
ast_done  in  1  one-cycle pulse: asteroid reached bottom (asteroid done)
destroyed  in  1  one-cycle acknowledge from asteroid that destroy was taken
bullet_x  in  8  bullet x
bullet_y  in  7  bullet y
bullet_valid  in  1  bullet on screen
destroy  out  1  level request to asteroid; held until destroyed
bullet_clear  out  1  one-cycle pulse: remove bullet
score  out  8  current score
lives  out  2  remaining lives
game_over  out  1  high in S_OVER

Behaviour:
- Reset (reset==0, async) values:
  - state=S_IDLE, destroy=0, bullet_clear=0, score=0, lives=0, game_over=0.
  - Both pipeline valid bits cleared.
- Overlap pipeline, 2 stages, each with its own valid bit:
  - Stage 1 registers dx=|ast_x-bullet_x| (8 bit) and dy=|ast_y-bullet_y| (7 bit). Valid = ast_active & bullet_valid.
  - Stage 2 registers hit = valid1 & (dx<=RADIUS) & (dy<=RADIUS).
  - Latency is 2 clocks from inputs to hit. Absolute differences are computed without wrap (compare, then subtract the smaller from the larger).
- States:
  - S_IDLE: outputs static. start -> S_PLAY; on that transition lives<=LIVES, score<=0, game_over<=0.
  - S_PLAY:
    - hit -> S_HIT; in the same cycle set destroy<=1, pulse bullet_clear for 1 cycle, and clear both valid bits.
    - Otherwise ast_done -> lives<=lives-1; if lives==1 -> S_OVER.
  - S_HIT: destroy held at 1. On destroyed: destroy<=0, score updated (below), -> S_PLAY. Pipeline valid bits are held at 0 while in S_HIT.
  - S_OVER: game_over=1, destroy=0. start -> S_PLAY with the same reload as from S_IDLE.
- Score arithmetic: score+SCORE_INC, saturating at 255. No wrap.
- Boundary rules:
  - hit and ast_done in the same cycle in S_PLAY: hit wins, no life lost.
  - ast_done while in S_HIT is ignored, since the asteroid is being destroyed.
  - lives never decrements below 0.
  - start while in S_PLAY or S_HIT is ignored.
  - destroyed while not in S_HIT is ignored.
  - Reset asserted mid-handshake drops destroy immediately (async).
  - bullet_valid low clears the stage-1 valid on the next clock, so a stale bullet never scores.

Optional Feature:
- Macro: ASTEROID_HIT_BCD_EN.
- Defined:
  - score is two packed BCD digits, score[7:4] tens and score[3:0] units, for direct hex-display drive.
  - The increment carries units 9->0 into tens.
  - Saturates at 8'h99.
  - SCORE_INC must be 1.
- Undefined: binary score saturating at 255, as above.

Decomposition:
- Shared package asteroid_pkg holds:
  - state encodings S_IDLE=2'b00, S_PLAY=2'b01, S_HIT=2'b10, S_OVER=2'b11
  - coordinate widths X_W=8, Y_W=7
  - default RADIUS=5
- One sub-module, hit_box_cmp: the 2-stage abs-diff/compare pipeline with valid bits and a flush input. The FSM and counters stay in the top.

Test Plan:
- Start, bullet at (51,40), asteroid at (54,43), both valid -> destroy rises 3 clocks after inputs (2 pipeline + FSM). bullet_clear pulses once. After destroyed pulse: destroy=0, score=1.
- Bullet at (60,40), asteroid at (54,40) (dx=6) -> no destroy over 20 cycles; score stays 0.
- Start, then three ast_done pulses with no hits -> lives 3,2,1,0; game_over=1 after the third; a further start restores lives=3, score=0.
- Hit detection and ast_done in the same cycle with lives=1 -> S_HIT entered, lives stays 1, no game_over.
- With score=255 (binary), or score=8'h99 with ASTEROID_HIT_BCD_EN, one more confirmed hit -> score unchanged. In BCD, 8'h09 + hit -> 8'h10.
- Assert reset low while destroy=1 and before destroyed -> destroy, score and lives go to 0 immediately, without waiting for a clock edge.
